multi_cycle_control_unit: RTL
=============================

// Module: multi_cycle_control_unit
// PURPOSE
//  Control FSM of the multi-cycle CPU. Sequences each instruction through IF/ID/EXE/MEM/WB.
//  Drives every datapath enable and mux select from the current state, the opcode held in IR, and the ALU flags.
//  Sits directly upstream of the datapath: the CPU top instantiates it next to PC, IR, regfile, ALU and data memory.
// PARAMETERS
//  OP_W     6  opcode width (IR[31:26])
//  ALUOP_W  3  ALU operation select width
// PORTS
//  CLK        in   1        system clock, rising edge
//  Reset      in   1        asynchronous, active-low reset
//  op         in   OP_W     opcode from IR; stable from ID onward
//  zero       in   1        ALU result == 0
//  sign       in   1        ALU result[31]
//  PCWre      out  1        PC write enable
//  IRWre      out  1        IR write enable
//  InsMemRW   out  1        1 = instruction memory read
//  RegWre     out  1        register file write enable
//  mRD, mWR   out  1 each   data memory read / write strobe
//  ALUSrcA    out  1        1 = shamt (sll), 0 = rs
//  ALUSrcB    out  1        1 = extended immediate, 0 = rt
//  DBDataSrc  out  1        1 = memory data, 0 = ALU result to WB latch
//  WrRegDSrc  out  1        1 = WB data, 0 = PC+4 (jal)
//  RegDst     out  2        00 = $31, 01 = rt, 10 = rd
//  ExtSel     out  1        1 = sign-extend, 0 = zero-extend
//  PCSrc      out  2        00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target
//  ALUOp      out  ALUOP_W  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt (signed)
//  illegal_op out  1        sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - State register, 3 bits: IF=000 ID=001 EXE_LS=010 MEM=011 WB_LD=100 EXE_BR=101 EXE_AL=110 WB_AL=111.
//  - Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, slti 100111,
//    sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
//  - Transitions:
//    - IF -> ID always.
//    - ID -> EXE_AL for ALU ops; EXE_BR for beq/bne/bltz; EXE_LS for sw/lw; IF for j/jr/jal; ID (self-loop) for halt.
//    - EXE_AL -> WB_AL -> IF.  EXE_BR -> IF.  EXE_LS -> MEM.  MEM -> IF (sw) or WB_LD (lw).  WB_LD -> IF.
//  - Instruction latency in cycles: ALU 4; branch 3; sw 4; lw 5; j/jr/jal 2; halt never completes.
//  - All outputs are combinational from (state, op, zero, sign). No output is registered except illegal_op.
//  - IF: InsMemRW=1, IRWre=1; all other enables 0.
//  - PCWre=1 only in the final state of an instruction: WB_AL, WB_LD, MEM(sw), EXE_BR, and ID(j/jr/jal).
//    PCWre=0 in ID for halt, so the PC freezes.
//  - PCSrc:
//    - EXE_BR: 01 if (beq & zero) | (bne & ~zero) | (bltz & sign), else 00.
//    - ID: jr=10, j/jal=11.
//    - All other states: 00.
//  - RegWre=1 only in WB_AL and WB_LD, and in ID for jal (RegDst=00, WrRegDSrc=0).
//  - RegDst: 10 for R-type, 01 for I-type.
//  - mWR=1 only in MEM for sw; mRD=1 in MEM and WB_LD for lw. mRD and mWR are never both 1.
//  - ExtSel=0 for ori, 1 otherwise.
//  - ALUSrcB=1 for addi/ori/slti/sw/lw. ALUOp=001 (sub) for beq/bne/bltz.
//  - ALUOp and the mux selects hold their decoded values in every state of the instruction (no glitching between EXE and WB).
//  - Reset low, asynchronous: state <= IF immediately, illegal_op <= 0.
//    While Reset is low, PCWre, IRWre, RegWre and mWR are forced to 0; all other outputs take their IF values.
//  - Reset mid-instruction discards the instruction; no partial writeback.
//  - The first IF occurs on the first rising edge after Reset deasserts.
// CONFIGURATION
//  - ILLEGAL_OP_TRAP_EN defined:
//    - An unlisted opcode in ID sets illegal_op=1 (sticky until reset).
//    - The FSM self-loops in ID with PCWre=0, i.e. behaves like halt.
//  - ILLEGAL_OP_TRAP_EN undefined:
//    - An unlisted opcode is a NOP: ID -> IF with PCWre=1, PCSrc=00, no writes.
//    - illegal_op is tied to 0.
// TESTING
//  - Reset=0 for 30 ns, then Reset=1 at 20 ns period:
//    -> state IF; PCWre=RegWre=mWR=IRWre=0 during reset; IRWre=1 in the first cycle after release.
//  - Sequence add, addi, lw, sw:
//    -> states IF,ID,EXE_AL,WB_AL / 4 / IF,ID,EXE_LS,MEM,WB_LD / IF,ID,EXE_LS,MEM.
//    -> PCWre pulses exactly once per instruction; mWR=1 only in sw's MEM cycle.
//  - Branches:
//    -> beq with zero=1 gives PCSrc=01 in EXE_BR; bne with zero=1 gives PCSrc=00.
//    -> bltz with sign=1 gives PCSrc=01; each branch takes 3 cycles.
//  - Jumps:
//    -> jal gives ID cycle with RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
//    -> jr gives PCSrc=10.
//  - Halt and reset mid-instruction:
//    -> op=111111 stays in ID with PCWre=0 for 10+ cycles.
//    -> Reset pulsed low mid-lw (in MEM) returns to IF asynchronously, with RegWre never asserted.
//  - op=101010:
//    -> with ILLEGAL_OP_TRAP_EN, illegal_op=1 and the FSM is stuck in ID.
//    -> without it, 2-cycle NOP with PCWre=1 in ID and illegal_op=0.

Source files
------------

// File: rtl/multi_cycle_control_unit_if.sv
// Control bus between the multi-cycle control unit and the datapath.
// The control unit drives every enable/select through the master modport.
interface multi_cycle_control_unit_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
);
    logic [OP_W-1:0]    op;
    logic               zero;
    logic               sign;
    logic               PCWre;
    logic               IRWre;
    logic               InsMemRW;
    logic               RegWre;
    logic               mRD;
    logic               mWR;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic               DBDataSrc;
    logic               WrRegDSrc;
    logic [1:0]         RegDst;
    logic               ExtSel;
    logic [1:0]         PCSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic               illegal_op;

    modport master (
        input  op, zero, sign,
        output PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
               DBDataSrc, WrRegDSrc, RegDst, ExtSel, PCSrc, ALUOp, illegal_op
    );

    modport slave (
        output op, zero, sign,
        input  PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
               DBDataSrc, WrRegDSrc, RegDst, ExtSel, PCSrc, ALUOp, illegal_op
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB) driving all datapath enables and selects.
// Optional ILLEGAL_OP_TRAP_EN: unlisted opcodes trap in ID and set sticky illegal_op.
module multi_cycle_control_unit #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic CLK,
    input  logic Reset,
    multi_cycle_control_unit_if.master bus
);
    localparam logic [2:0] S_IF     = 3'b000;
    localparam logic [2:0] S_ID     = 3'b001;
    localparam logic [2:0] S_EXE_LS = 3'b010;
    localparam logic [2:0] S_MEM    = 3'b011;
    localparam logic [2:0] S_WB_LD  = 3'b100;
    localparam logic [2:0] S_EXE_BR = 3'b101;
    localparam logic [2:0] S_EXE_AL = 3'b110;
    localparam logic [2:0] S_WB_AL  = 3'b111;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110101);
    localparam logic [OP_W-1:0] OP_BLTZ = OP_W'(6'b110110);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b101);

`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [2:0]         state_q, state_d;
    logic               illegal_op_q, illegal_op_d;
    logic               is_rtype_s, is_ialu_s, is_sll_s, is_ori_s;
    logic               is_beq_s, is_bne_s, is_bltz_s, is_sw_s, is_lw_s;
    logic               is_j_s, is_jr_s, is_jal_s, is_halt_s;
    logic               is_alu_s, is_branch_s, is_legal_s, br_taken_s;
    logic [ALUOP_W-1:0] alu_op_s;
    logic               pc_wre_s, ir_wre_s, reg_wre_s, m_wr_s, m_rd_s, ins_rd_s;
    logic [1:0]         pc_src_s;

    // Opcode classification and ALU operation decode
    always_comb begin
        is_rtype_s = 1'b0; is_ialu_s = 1'b0; is_sll_s = 1'b0; is_ori_s = 1'b0;
        is_beq_s   = 1'b0; is_bne_s  = 1'b0; is_bltz_s = 1'b0;
        is_sw_s    = 1'b0; is_lw_s   = 1'b0;
        is_j_s     = 1'b0; is_jr_s   = 1'b0; is_jal_s = 1'b0; is_halt_s = 1'b0;
        alu_op_s   = ALU_ADD;
        case (bus.op)
            OP_ADD:  is_rtype_s = 1'b1;
            OP_SUB:  begin is_rtype_s = 1'b1; alu_op_s = ALU_SUB; end
            OP_OR:   begin is_rtype_s = 1'b1; alu_op_s = ALU_OR;  end
            OP_AND:  begin is_rtype_s = 1'b1; alu_op_s = ALU_AND; end
            OP_SLL:  begin is_rtype_s = 1'b1; is_sll_s = 1'b1; alu_op_s = ALU_SLL; end
            OP_SLT:  begin is_rtype_s = 1'b1; alu_op_s = ALU_SLT; end
            OP_ADDI: is_ialu_s = 1'b1;
            OP_ORI:  begin is_ialu_s = 1'b1; is_ori_s = 1'b1; alu_op_s = ALU_OR; end
            OP_SLTI: begin is_ialu_s = 1'b1; alu_op_s = ALU_SLT; end
            OP_SW:   is_sw_s = 1'b1;
            OP_LW:   is_lw_s = 1'b1;
            OP_BEQ:  begin is_beq_s  = 1'b1; alu_op_s = ALU_SUB; end
            OP_BNE:  begin is_bne_s  = 1'b1; alu_op_s = ALU_SUB; end
            OP_BLTZ: begin is_bltz_s = 1'b1; alu_op_s = ALU_SUB; end
            OP_J:    is_j_s    = 1'b1;
            OP_JR:   is_jr_s   = 1'b1;
            OP_JAL:  is_jal_s  = 1'b1;
            OP_HALT: is_halt_s = 1'b1;
            default: alu_op_s  = ALU_ADD;
        endcase
    end

    assign is_alu_s    = is_rtype_s | is_ialu_s;
    assign is_branch_s = is_beq_s | is_bne_s | is_bltz_s;
    assign is_legal_s  = is_alu_s | is_branch_s | is_sw_s | is_lw_s |
                         is_j_s | is_jr_s | is_jal_s | is_halt_s;
    assign br_taken_s  = (is_beq_s & bus.zero) | (is_bne_s & ~bus.zero) | (is_bltz_s & bus.sign);

    // State and sticky trap flag registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IF;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d      = S_IF;
        illegal_op_d = illegal_op_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_alu_s) begin
                    state_d = S_EXE_AL;
                end else if (is_branch_s) begin
                    state_d = S_EXE_BR;
                end else if (is_sw_s | is_lw_s) begin
                    state_d = S_EXE_LS;
                end else if (is_halt_s) begin
                    state_d = S_ID;
                end else if (!is_legal_s) begin
                    state_d      = TRAP_EN ? S_ID : S_IF;
                    illegal_op_d = illegal_op_q | TRAP_EN;
                end else begin
                    state_d = S_IF;
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw_s ? S_WB_LD : S_IF;
            default:  state_d = S_IF;
        endcase
    end

    // Per-state enables; selects follow the held opcode in every state
    always_comb begin
        pc_wre_s  = 1'b0; ir_wre_s = 1'b0; reg_wre_s = 1'b0;
        m_wr_s    = 1'b0; m_rd_s   = 1'b0; ins_rd_s  = 1'b0;
        pc_src_s  = 2'b00;
        case (state_q)
            S_IF: begin
                ins_rd_s = 1'b1;
                ir_wre_s = 1'b1;
            end
            S_ID: begin
                if (is_jr_s) begin
                    pc_wre_s = 1'b1;
                    pc_src_s = 2'b10;
                end else if (is_j_s | is_jal_s) begin
                    pc_wre_s  = 1'b1;
                    pc_src_s  = 2'b11;
                    reg_wre_s = is_jal_s;
                end else begin
                    pc_wre_s = ~is_legal_s & ~TRAP_EN;
                end
            end
            S_EXE_BR: begin
                pc_wre_s = 1'b1;
                pc_src_s = br_taken_s ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                pc_wre_s = is_sw_s;
                m_wr_s   = is_sw_s;
                m_rd_s   = is_lw_s;
            end
            S_WB_LD: begin
                pc_wre_s  = 1'b1;
                reg_wre_s = 1'b1;
                m_rd_s    = is_lw_s;
            end
            S_WB_AL: begin
                pc_wre_s  = 1'b1;
                reg_wre_s = 1'b1;
            end
            default: pc_src_s = 2'b00;
        endcase
    end

    assign bus.PCWre      = pc_wre_s  & Reset;
    assign bus.IRWre      = ir_wre_s  & Reset;
    assign bus.RegWre     = reg_wre_s & Reset;
    assign bus.mWR        = m_wr_s    & Reset;
    assign bus.mRD        = m_rd_s;
    assign bus.InsMemRW   = ins_rd_s;
    assign bus.PCSrc      = pc_src_s;
    assign bus.ALUOp      = alu_op_s;
    assign bus.ALUSrcA    = is_sll_s;
    assign bus.ALUSrcB    = is_ialu_s | is_sw_s | is_lw_s;
    assign bus.DBDataSrc  = is_lw_s;
    assign bus.WrRegDSrc  = ~is_jal_s;
    assign bus.RegDst     = is_jal_s ? 2'b00 : (is_rtype_s ? 2'b10 : 2'b01);
    assign bus.ExtSel     = ~is_ori_s;
    assign bus.illegal_op = illegal_op_q;
endmodule
